// File: rtl/cnn_frame_sequencer_if.sv
// cnn_frame_sequencer_if: host pixel stream, CNN_TOP link and host result handshake
interface cnn_frame_sequencer_if #(
    parameter int RESULT_W = 48
);
    logic                       frame_req;
    logic                       abort;
    logic                       s_pix_valid;
    logic [7:0]                 s_pix_data;
    logic                       s_pix_ready;
    logic                       start_signal;
    logic                       pixel_valid;
    logic [7:0]                 pixel_in;
    logic                       final_result_valid;
    logic signed [RESULT_W-1:0] final_lane_result;
    logic                       res_valid;
    logic signed [RESULT_W-1:0] res_data;
    logic                       res_ready;
    logic                       busy;
    logic [1:0]                 err_code;
    logic [15:0]                frame_cnt;

    modport slave (
        input  frame_req, abort, s_pix_valid, s_pix_data, final_result_valid,
               final_lane_result, res_ready,
        output s_pix_ready, start_signal, pixel_valid, pixel_in, res_valid,
               res_data, busy, err_code, frame_cnt
    );

    modport master (
        output frame_req, abort, s_pix_valid, s_pix_data, final_result_valid,
               final_lane_result, res_ready,
        input  s_pix_ready, start_signal, pixel_valid, pixel_in, res_valid,
               res_data, busy, err_code, frame_cnt
    );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: sequences one CNN_TOP inference per host frame request
module cnn_frame_sequencer #(
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int TIMEOUT_CYC = 50000,
    parameter int START_GAP   = 1
) (
    input logic                  clk,
    input logic                  rst,
    cnn_frame_sequencer_if.slave bus
);
    localparam int IMG_SIZE = IMG_WIDTH * IMG_HEIGHT;
    localparam int PW = $clog2(IMG_SIZE);
    localparam int TW = $clog2(TIMEOUT_CYC > START_GAP ? TIMEOUT_CYC : START_GAP);

    typedef enum logic [2:0] {IDLE, START, GAP, STREAM, WAIT_RES, DONE, ERR} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pix_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          accept, early, handshake, abort_eff;

    assign accept    = bus.s_pix_valid && state == STREAM;
    assign early     = bus.final_result_valid && (state == START || state == GAP || state == STREAM);
    assign handshake = state == DONE && bus.res_ready;
    // a result handshake in DONE completes even when abort arrives with it
    assign abort_eff = bus.abort && state != IDLE && !handshake;

    assign bus.s_pix_ready  = state == STREAM;
    assign bus.start_signal = state == START;
    assign bus.res_valid    = state == DONE;
    assign bus.busy         = state != IDLE;

    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    // next-state: early result and timeout divert to ERR, abort overrides everything
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = bus.frame_req ? START : IDLE;
            START:    state_nx = early ? ERR : GAP;
            GAP:      state_nx = early ? ERR : (tmo_cnt == TW'(START_GAP - 1)) ? STREAM : GAP;
            STREAM:   state_nx = early ? ERR : (accept && pix_cnt == PW'(IMG_SIZE - 1)) ? WAIT_RES : STREAM;
            WAIT_RES: state_nx = bus.final_result_valid ? DONE : (tmo_cnt == TW'(TIMEOUT_CYC - 1)) ? ERR : WAIT_RES;
            DONE:     state_nx = bus.res_ready ? IDLE : DONE;
            default:  state_nx = IDLE;
        endcase
        if (abort_eff) state_nx = IDLE;
    end

    // counters, registered pixel forwarding, result capture, error code and frame count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt         <= '0;
            tmo_cnt         <= '0;
            bus.pixel_valid <= 1'b0;
            bus.pixel_in    <= '0;
            bus.res_data    <= '0;
            bus.err_code    <= 2'b00;
            bus.frame_cnt   <= '0;
        end else begin
            pix_cnt         <= (state_nx == STREAM) ? pix_cnt + PW'(accept) : '0;
            tmo_cnt         <= (state_nx == state && (state == GAP || state == WAIT_RES)) ? tmo_cnt + TW'(1) : '0;
            bus.pixel_valid <= accept && !bus.abort;
            if (accept) bus.pixel_in <= bus.s_pix_data;
            if (state == WAIT_RES && state_nx == DONE) bus.res_data <= bus.final_lane_result;
            if (state == IDLE && bus.frame_req) bus.err_code <= 2'b00;
            else if (abort_eff) bus.err_code <= 2'b11;
            else if (state_nx == ERR) bus.err_code <= (state == WAIT_RES) ? 2'b01 : 2'b10;
            bus.frame_cnt   <= bus.frame_cnt + 16'(handshake);
        end
    end
endmodule
